// File: rtl/video_awb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// video_awb_mul_arbiter
//
// Shares one DATA_W x DATA_W unsigned gain multiplier between NUM_REQ AWB
// channel requesters (R, G, B by default). A round-robin arbiter grants at
// most one requester per cycle into a two-stage pipeline:
//   stage 1 : operand register (pixel, gain, requester id)
//   stage 2 : multiply, round, rescale from Q(DATA_W-FRAC_BITS).FRAC_BITS,
//             saturate to DATA_W bits, register the tagged result
//
// Ports
//   ap_clk      clock
//   ap_rst_n    asynchronous active-low reset (deassertion synchronised)
//   req_valid   per-requester operand valid
//   req_ready   per-requester accept, one-hot grant (combinational)
//   req_pix     packed pixel operands, requester i at [i*DATA_W +: DATA_W]
//   req_gain    packed gain operands, same packing as req_pix
//   res_valid   result valid
//   res_ready   downstream accept
//   res_id      requester that produced the result
//   res_data    rounded, rescaled, saturated result
//   res_sat     result was clamped to the maximum code
//   busy        either pipeline stage holds an item
//
// Optional feature (macro VIDEO_AWB_MUL_ARB_STATS_EN)
//   stat_clr    synchronous clear of all grant counters
//   stat_cnt    NUM_REQ packed 16-bit saturating grant counters
// ---------------------------------------------------------------------------
module video_awb_mul_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int DATA_W    = 12,
  parameter int FRAC_BITS = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_pix,
  input  logic [NUM_REQ*DATA_W-1:0]   req_gain,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [1:0]                  res_id,
  output logic [DATA_W-1:0]           res_data,
  output logic                        res_sat,
`ifdef VIDEO_AWB_MUL_ARB_STATS_EN
  input  logic                        stat_clr,
  output logic [NUM_REQ*16-1:0]       stat_cnt,
`endif
  output logic                        busy
);

  localparam int PW     = 2 * DATA_W;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  // Half an LSB of the rescaled result, added before the shift to round.
  localparam logic [PW:0] RND_C = (FRAC_BITS > 0) ? ((PW+1)'(1) << RND_SH) : '0;
  localparam logic [DATA_W-1:0] SAT_MAX = '1;
  localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

  // Reset synchroniser: reset asserts asynchronously everywhere, but the
  // arbiter only starts granting two clean edges after ap_rst_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       run;

  // Pipeline and arbitration state.
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_pix_q, s1_pix_d;
  logic [DATA_W-1:0] s1_gain_q, s1_gain_d;
  logic [1:0]        s1_id_q, s1_id_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_sat_q, res_sat_d;
  logic [1:0]        res_id_q, res_id_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;

  // Flow control and arbitration results.
  logic               s2_adv, s1_adv, can_accept;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_id;
  logic               grant_any;
  int                 arb_dist, arb_best;

  // Datapath intermediates.
  logic [PW-1:0]     prod;
  logic [PW:0]       rnd;
  logic [PW:0]       sh;
  logic              sat_hit;
  logic [DATA_W-1:0] mul_data;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run        = rst_sync_q[1];

  // The output register can take a new item when empty or being drained;
  // stage 1 can take a new operand when empty or moving forward.
  assign s2_adv     = !res_valid_q || res_ready;
  assign s1_adv     = s1_valid_q && s2_adv;
  assign can_accept = run && (!s1_valid_q || s2_adv);

  // Round-robin search: the valid requester at the smallest distance
  // above rr_ptr (modulo NUM_REQ) wins.
  always_comb begin
    arb_dist = 0;
    arb_best = NUM_REQ;
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        arb_dist = i - int'(rr_ptr_q);
        if (arb_dist < 0) arb_dist = arb_dist + NUM_REQ;
        if (arb_dist < arb_best) begin
          arb_best = arb_dist;
          grant_id = 2'(i);
        end
      end
    end
    grant_any = can_accept && (arb_best < NUM_REQ);
    grant     = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  end

  assign req_ready = grant;

  // Pointer moves just past the winner so it becomes lowest priority.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_id == LAST_ID) ? 2'd0 : grant_id + 2'd1;
    end
  end

  // Stage 1 loads the granted operands; otherwise it empties when its
  // item moves into the output register.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_gain_d  = s1_gain_q;
    s1_id_d    = s1_id_q;
    if (grant_any) begin
      s1_valid_d = 1'b1;
      s1_id_d    = grant_id;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          s1_pix_d  = req_pix[i*DATA_W +: DATA_W];
          s1_gain_d = req_gain[i*DATA_W +: DATA_W];
        end
      end
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Multiply, round half up, drop the fractional bits and clamp.
  // The extra top bit of rnd keeps the rounding add from overflowing.
  always_comb begin
    prod     = PW'(s1_pix_q) * PW'(s1_gain_q);
    rnd      = {1'b0, prod} + RND_C;
    sh       = rnd >> FRAC_BITS;
    sat_hit  = |sh[PW:DATA_W];
    mul_data = sat_hit ? SAT_MAX : sh[DATA_W-1:0];
  end

  // Output register: loads when stage 1 advances, otherwise drops valid
  // once accepted. Data fields keep their last value when idle.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sat_d   = res_sat_q;
    res_id_d    = res_id_q;
    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_data_d  = mul_data;
      res_sat_d   = sat_hit;
      res_id_d    = s1_id_q;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // All control and data state, cleared asynchronously.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_gain_q   <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rst_sync_q  <= rst_sync_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_gain_q   <= s1_gain_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sat_q   <= res_sat_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q || res_valid_q;

`ifdef VIDEO_AWB_MUL_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  // Per-requester grant counters; clear wins over increment and the
  // count sticks at 0xFFFF instead of wrapping.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (grant[i] && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*16 +: 16] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_video_awb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_video_awb_mul_arbiter
//
// Drives directed and randomised traffic into video_awb_mul_arbiter and
// compares every cycle against a transaction-level reference: results are
// computed with integer arithmetic, the pipeline is a queue of in-flight
// items, and arbitration is a plain modulo round-robin search.
// ---------------------------------------------------------------------------
module tb_video_awb_mul_arbiter;

   localparam int N = 3;
   localparam int W = 12;
   localparam int F = 8;

   typedef struct {
      int id;
      int data;
      bit sat;
      bit atOut;
   } item_t;

   logic           clk = 1'b0;
   logic           rstN = 1'b1;
   logic [N-1:0]   reqValid;
   logic [N-1:0]   reqReady;
   logic [N*W-1:0] reqPix;
   logic [N*W-1:0] reqGain;
   logic           resValid;
   logic           resReady;
   logic [1:0]     resId;
   logic [W-1:0]   resData;
   logic           resSat;
   logic           busyOut;
`ifdef VIDEO_AWB_MUL_ARB_STATS_EN
   logic           statClr = 1'b0;
   logic [N*16-1:0] statCnt;
`endif

   int checks = 0;
   int errors = 0;

   item_t pipe[$];
   int    rrPtr;
   int    lastData;
   int    lastId;
   bit    lastSat;
   int    expGrant;
   int    pixOp[N];
   int    gainOp[N];
   int    left[N];
   int    resSeen;
   bit    stallMode;
   int    stallAccepts;

   video_awb_mul_arbiter #(.NUM_REQ(N), .DATA_W(W), .FRAC_BITS(F)) dut (
      .ap_clk    (clk),
      .ap_rst_n  (rstN),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_pix   (reqPix),
      .req_gain  (reqGain),
      .res_valid (resValid),
      .res_ready (resReady),
      .res_id    (resId),
      .res_data  (resData),
      .res_sat   (resSat),
`ifdef VIDEO_AWB_MUL_ARB_STATS_EN
      .stat_clr  (statClr),
      .stat_cnt  (statCnt),
`endif
      .busy      (busyOut)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   // Hard stop in case something upstream of the bounded loops wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Q4.8 gain applied with round-half-up and clamp to the 12-bit range.
   function automatic void expectedResult(input int pix, input int gain, output int data, output bit sat);
      int half;
      int scaled;
      half   = (F > 0) ? (1 << (F - 1)) : 0;
      scaled = (pix * gain + half) >> F;
      if (scaled > (1 << W) - 1) begin
         data = (1 << W) - 1;
         sat  = 1'b1;
      end else begin
         data = scaled;
         sat  = 1'b0;
      end
   endfunction

   function automatic void newOperands(input int i);
      pixOp[i]  = $urandom_range(0, 4095);
      gainOp[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4095) : $urandom_range(0, 511);
   endfunction

   task automatic driveReq();
      for (int i = 0; i < N; i++) begin
         reqPix[i*W +: W]  = pixOp[i][W-1:0];
         reqGain[i*W +: W] = gainOp[i][W-1:0];
         reqValid[i]       = (left[i] > 0);
      end
   endtask

   task automatic resetModel();
      pipe.delete();
      rrPtr    = 0;
      lastData = 0;
      lastId   = 0;
      lastSat  = 1'b0;
      expGrant = -1;
   endtask

   // Mid-cycle comparison of every DUT output against the reference.
   task automatic checkOutput(input bit waitEdge);
      bit outFull;
      bit s1Full;
      bit outFree;
      bit accept;
      if (waitEdge) @(negedge clk);
      outFull  = (pipe.size() > 0) && pipe[0].atOut;
      s1Full   = pipe.size() > (outFull ? 1 : 0);
      outFree  = !outFull || resReady;
      accept   = !s1Full || outFree;
      expGrant = -1;
      if (accept) begin
         for (int k = 0; k < N; k++) begin
            int id;
            id = (rrPtr + k) % N;
            if (expGrant < 0 && left[id] > 0) expGrant = id;
         end
      end
      checkVal("req_ready", reqReady, (expGrant >= 0) ? (1 << expGrant) : 0);
      checkVal("res_valid", resValid, outFull);
      checkVal("busy", busyOut, pipe.size() > 0);
      checkVal("res_data", resData, lastData);
      checkVal("res_id", resId, lastId);
      checkVal("res_sat", resSat, lastSat);
      if (resValid && resReady) resSeen++;
      if (stallMode && ((reqReady & reqValid) != 0)) stallAccepts++;
   endtask

   // Clock edge: retire, advance and admit items in the reference, then
   // let the granted requester present its next operand.
   task automatic applyStimulus();
      bit outFull;
      bit s1Full;
      bit outFree;
      int g;
      outFull = (pipe.size() > 0) && pipe[0].atOut;
      s1Full  = pipe.size() > (outFull ? 1 : 0);
      outFree = !outFull || resReady;
      g       = expGrant;
      @(posedge clk);
      if (outFull && resReady) void'(pipe.pop_front());
      if (s1Full && outFree) begin
         foreach (pipe[i]) begin
            if (!pipe[i].atOut) begin
               pipe[i].atOut = 1'b1;
               lastData = pipe[i].data;
               lastId   = pipe[i].id;
               lastSat  = pipe[i].sat;
            end
         end
      end
      if (g >= 0) begin
         item_t it;
         expectedResult(pixOp[g], gainOp[g], it.data, it.sat);
         it.id    = g;
         it.atOut = 1'b0;
         pipe.push_back(it);
         rrPtr = (g + 1) % N;
      end
      #1;
      if (g >= 0) begin
         left[g]--;
         if (left[g] > 0) newOperands(g);
      end
      driveReq();
   endtask

   task automatic step(input int n);
      for (int c = 0; c < n; c++) begin
         checkOutput(1'b1);
         applyStimulus();
      end
   endtask

   // Linear sequence of directed and randomised scenarios.
   initial begin
      bit found;
      resReady     = 1'b1;
      resSeen      = 0;
      stallMode    = 1'b0;
      stallAccepts = 0;
      for (int i = 0; i < N; i++) begin
         left[i] = 1;
         newOperands(i);
      end
      driveReq();
      resetModel();

      // Power-on reset with every requester asking: nothing may be granted.
      #1 rstN = 1'b0;
      #2;
      checkVal("rst_req_ready", reqReady, 0);
      checkVal("rst_res_valid", resValid, 0);
      checkVal("rst_res_data", resData, 0);
      checkVal("rst_res_id", resId, 0);
      checkVal("rst_res_sat", resSat, 0);
      checkVal("rst_busy", busyOut, 0);
      for (int i = 0; i < N; i++) left[i] = 0;
      driveReq();
      @(posedge clk);
      #1 rstN = 1'b1;
      step(4);

      // Unity gain on requester 0.
      pixOp[0] = 'h800; gainOp[0] = 'h100; left[0] = 1; driveReq();
      step(2);
      checkVal("unity_valid", resValid, 1);
      checkVal("unity_data", resData, 'h800);
      checkVal("unity_sat", resSat, 0);
      checkVal("unity_id", resId, 0);
      step(2);

      // Saturation on requester 1.
      pixOp[1] = 'hFFF; gainOp[1] = 'h200; left[1] = 1; driveReq();
      step(2);
      checkVal("sat_data", resData, 'hFFF);
      checkVal("sat_flag", resSat, 1);
      checkVal("sat_id", resId, 1);
      step(2);

      // Rounding on requester 2: up to 2, then down to 0.
      pixOp[2] = 3; gainOp[2] = 'h080; left[2] = 1; driveReq();
      step(2);
      checkVal("round_up_data", resData, 2);
      step(2);
      pixOp[2] = 1; gainOp[2] = 'h07F; left[2] = 1; driveReq();
      step(2);
      checkVal("round_down_data", resData, 0);
      checkVal("round_down_id", resId, 2);
      step(2);

      // Fairness: all three continuously valid at full throughput.
      for (int i = 0; i < N; i++) begin
         left[i] = 6;
         newOperands(i);
      end
      driveReq();
      step(24);

      // Backpressure: six items from requester 0 with a five-cycle stall.
      resSeen = 0;
      left[0] = 6; newOperands(0); driveReq();
      step(3);
      resReady = 1'b0; stallMode = 1'b1;
      step(5);
      stallMode = 1'b0; resReady = 1'b1;
      step(8);
      checkVal("bp_results", resSeen, 6);
      checkVal("bp_stall_accepts_le2", stallAccepts <= 2, 1);

      // Random traffic with random backpressure, then drain.
      for (int c = 0; c < 300; c++) begin
         resReady = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (left[i] == 0 && $urandom_range(0, 2) == 0) begin
               left[i] = $urandom_range(1, 4);
               newOperands(i);
            end
         end
         driveReq();
         step(1);
      end
      resReady = 1'b1;
      step(30);

      // Reset with both stages occupied.
      for (int i = 0; i < N; i++) begin
         left[i] = 5;
         newOperands(i);
      end
      resReady = 1'b0;
      driveReq();
      step(3);
      checkVal("pre_reset_busy", busyOut, 1);
      rstN = 1'b0;
      #1;
      checkVal("mid_rst_req_ready", reqReady, 0);
      checkVal("mid_rst_res_valid", resValid, 0);
      checkVal("mid_rst_res_data", resData, 0);
      checkVal("mid_rst_res_id", resId, 0);
      checkVal("mid_rst_res_sat", resSat, 0);
      checkVal("mid_rst_busy", busyOut, 0);
      resetModel();
      left[0] = 1; left[1] = 1; left[2] = 0;
      newOperands(0); newOperands(1);
      resReady = 1'b1;
      driveReq();
      @(posedge clk);
      @(posedge clk);
      #1 rstN = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (reqReady != 0) found = 1'b1;
         else @(posedge clk);
      end
      checkVal("post_rst_grant_seen", found, 1);
      if (found) begin
         checkVal("post_rst_first_grant", reqReady, 3'b001);
         checkOutput(1'b0);
         applyStimulus();
         step(6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
